// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - instruction ROM with combinational fetch port and byte-serial load port
module inst_rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [31:0]       addr_i,
    output logic [31:0]       inst_o,
    output logic              busy_o,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_byte_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              ld_done_o,
    output logic              ld_err_o,
    output logic [ADDR_W:0]   ld_words_o
);

    localparam int             DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              done_q, done_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [31:0]       merged;
    logic              in_range;
    logic              unused_addr_bits;
    logic [31:0]       mem [DEPTH];

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        words_d    = words_q;
        done_d     = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = words_q[ADDR_W-1:0];
        // Big-endian packing: byte k of a word lands at bits [31-8k -: 8].
        merged     = asm_q | ({ld_byte_i, 24'h0} >> {byte_cnt_q, 3'b000});
        mem_wdata  = merged;

        if (ld_start_i) begin
            state_d    = ST_LOAD;
            byte_cnt_d = 2'd0;
            asm_d      = 32'h0;
            words_d    = '0;
        end else if (ld_valid_i && state_q == ST_LOAD) begin
            if (byte_cnt_q == 2'd0 && words_q == FULL) begin
                state_d = ST_ERR;
            end else if (byte_cnt_q == 2'd3 || ld_last_i) begin
                mem_we     = 1'b1;
                asm_d      = 32'h0;
                byte_cnt_d = 2'd0;
                words_d    = (words_q == FULL) ? words_q : words_q + 1'b1;
                if (ld_last_i) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end else begin
                asm_d      = merged;
                byte_cnt_d = byte_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'h0;
            words_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            words_q    <= words_d;
            done_q     <= done_d;
        end
    end

    // Memory is not reset; writes are suppressed during reset since state_q is IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign in_range         = (addr_i[31:ADDR_W+2] == '0);
    assign unused_addr_bits = ^addr_i[1:0];
    assign inst_o = (ce_i && state_q == ST_IDLE && in_range) ? mem[addr_i[ADDR_W+1:2]] : 32'h0;

    assign busy_o     = (state_q != ST_IDLE);
    assign ld_ready_o = (state_q == ST_LOAD);
    assign ld_err_o   = (state_q == ST_ERR);
    assign ld_done_o  = done_q;
    assign ld_words_o = words_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - self-checking bench for inst_rom_loader against a word-level memory model
module tb_inst_rom_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst;
    logic          ce_i;
    logic [31:0]   addr_i;
    logic [31:0]   inst_o;
    logic          busy_o;
    logic          ld_start_i;
    logic          ld_valid_i;
    logic [7:0]    ld_byte_i;
    logic          ld_last_i;
    logic          ld_ready_o;
    logic          ld_done_o;
    logic          ld_err_o;
    logic [AW:0]   ld_words_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] mm [DEPTH];
    bit          mvalid [DEPTH];

    inst_rom_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(inst_o),
        .busy_o(busy_o), .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i),
        .ld_byte_i(ld_byte_i), .ld_last_i(ld_last_i), .ld_ready_o(ld_ready_o),
        .ld_done_o(ld_done_o), .ld_err_o(ld_err_o), .ld_words_o(ld_words_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte i of a load goes to word i/4, lane 3-(i%4); only full words
    // or the final partial word (when last is flagged) are committed.
    task automatic model_load(input bq_t b, input bit last, output int exp_words, output bit exp_err);
        int n;
        n = b.size();
        exp_words = 0;
        exp_err   = 1'b0;
        for (int w = 0; w * 4 < n; w++) begin
            int k;
            logic [31:0] word;
            if (w >= DEPTH) begin
                exp_err = 1'b1;
                break;
            end
            k = (n - w * 4 < 4) ? n - w * 4 : 4;
            if (k == 4 || last) begin
                word = 32'h0;
                for (int j = 0; j < k; j++) word = word | (32'(b[w * 4 + j]) << (24 - 8 * j));
                mm[w]     = word;
                mvalid[w] = 1'b1;
                exp_words++;
            end
        end
    endtask

    task automatic send(input bq_t b, input bit last, input int gap_max);
        for (int i = 0; i < b.size(); i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                ld_valid_i = 1'b0;
                tick();
            end
            ld_valid_i = 1'b1;
            ld_byte_i  = b[i];
            ld_last_i  = last && (i == b.size() - 1);
            checks++;
            if (ld_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL ready_during_load byte %0d: got %b expected 1", i, ld_ready_o);
            end
            tick();
        end
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
    endtask

    task automatic start_pulse();
        ld_start_i = 1'b1;
        tick();
        ld_start_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({ld_ready_o, ld_done_o, ld_err_o, busy_o} !== 4'b0 || ld_words_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b done=%b err=%b busy=%b words=%0d expected all 0",
                     ld_ready_o, ld_done_o, ld_err_o, busy_o, ld_words_o);
        end
        ce_i = 1'b0;
        addr_i = 32'h0;
        #1;
        checks++;
        if (inst_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_inst: got %h expected 00000000", inst_o);
        end
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_full_word();
        bq_t b;
        int ew;
        bit ee;
        b = '{8'h34, 8'h01, 8'h00, 8'h20, 8'h34, 8'h02, 8'h00, 8'h30};
        start_pulse();
        ce_i = 1'b1;
        addr_i = 32'h0;
        #1;
        checks++;
        if (inst_o !== 32'h0) begin
            errors++;
            $display("FAIL fetch_during_load: got %h expected 00000000", inst_o);
        end
        ce_i = 1'b0;
        send(b, 1'b1, 0);
        model_load(b, 1'b1, ew, ee);
        checks++;
        if (ld_done_o !== 1'b1 || ld_words_o !== (AW+1)'(ew) || busy_o !== 1'b0 || ld_words_o !== 3'd2) begin
            errors++;
            $display("FAIL full_done: got done=%b words=%0d busy=%b expected 1 2 0", ld_done_o, ld_words_o, busy_o);
        end
        tick();
        checks++;
        if (ld_done_o !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: got %b expected 0", ld_done_o);
        end
        ce_i = 1'b1;
        addr_i = 32'd0; #1;
        checks++;
        if (inst_o !== 32'h34010020) begin
            errors++;
            $display("FAIL fetch_addr0: got %h expected 34010020", inst_o);
        end
        addr_i = 32'd4; #1;
        checks++;
        if (inst_o !== 32'h34020030) begin
            errors++;
            $display("FAIL fetch_addr4: got %h expected 34020030", inst_o);
        end
        addr_i = 32'd5; #1;
        checks++;
        if (inst_o !== 32'h34020030) begin
            errors++;
            $display("FAIL fetch_addr5: got %h expected 34020030", inst_o);
        end
        ce_i = 1'b0;
    endtask

    task automatic test_partial();
        bq_t b;
        int ew;
        bit ee;
        b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        start_pulse();
        send(b, 1'b1, 1);
        model_load(b, 1'b1, ew, ee);
        checks++;
        if (ld_words_o !== (AW+1)'(ew) || ld_words_o !== 3'd2 || ld_done_o !== 1'b1) begin
            errors++;
            $display("FAIL partial_words: got words=%0d done=%b expected 2 1", ld_words_o, ld_done_o);
        end
        ce_i = 1'b1;
        addr_i = 32'd6; #1;
        checks++;
        if (inst_o !== 32'hEEFF0000 || inst_o !== mm[1]) begin
            errors++;
            $display("FAIL partial_word1: got %h expected eeff0000", inst_o);
        end
        ce_i = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        bq_t b;
        int ew;
        bit ee;
        b = {};
        for (int i = 0; i < 4 * DEPTH + 1; i++) b.push_back(8'($urandom));
        start_pulse();
        send(b, 1'b0, 0);
        model_load(b, 1'b0, ew, ee);
        checks++;
        if (ld_err_o !== ee || ld_err_o !== 1'b1 || busy_o !== 1'b1 || ld_ready_o !== 1'b0 ||
            ld_words_o !== (AW+1)'(ew)) begin
            errors++;
            $display("FAIL overflow_state: got err=%b busy=%b rdy=%b words=%0d expected 1 1 0 %0d",
                     ld_err_o, busy_o, ld_ready_o, ld_words_o, ew);
        end
        ce_i = 1'b1;
        addr_i = 32'd0; #1;
        checks++;
        if (inst_o !== 32'h0) begin
            errors++;
            $display("FAIL fetch_in_err: got %h expected 00000000", inst_o);
        end
        ce_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (ld_err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_held: got %b expected 1", ld_err_o);
        end
        start_pulse();
        checks++;
        if (ld_err_o !== 1'b0 || ld_ready_o !== 1'b1 || ld_words_o !== '0) begin
            errors++;
            $display("FAIL err_cleared: got err=%b rdy=%b words=%0d expected 0 1 0", ld_err_o, ld_ready_o, ld_words_o);
        end
        b = '{8'h5A};
        send(b, 1'b1, 0);
        model_load(b, 1'b1, ew, ee);
        tick();
    endtask

    task automatic test_boundary_full();
        bq_t b;
        int ew;
        bit ee;
        b = {};
        for (int i = 0; i < 4 * DEPTH; i++) b.push_back(8'($urandom));
        start_pulse();
        send(b, 1'b1, 1);
        model_load(b, 1'b1, ew, ee);
        checks++;
        if (ld_err_o !== 1'b0 || ld_done_o !== 1'b1 || ld_words_o !== (AW+1)'(DEPTH) || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL boundary_full: got err=%b done=%b words=%0d busy=%b expected 0 1 %0d 0",
                     ld_err_o, ld_done_o, ld_words_o, busy_o, DEPTH);
        end
        tick();
    endtask

    task automatic test_gating();
        ce_i = 1'b1;
        addr_i = 32'h1000_0000; #1;
        checks++;
        if (inst_o !== 32'h0) begin
            errors++;
            $display("FAIL gate_far: got %h expected 00000000", inst_o);
        end
        addr_i = 32'(4 * DEPTH); #1;
        checks++;
        if (inst_o !== 32'h0) begin
            errors++;
            $display("FAIL gate_just_above: got %h expected 00000000", inst_o);
        end
        addr_i = 32'(4 * DEPTH - 1); #1;
        checks++;
        if (inst_o !== mm[DEPTH-1]) begin
            errors++;
            $display("FAIL gate_top_word: got %h expected %h", inst_o, mm[DEPTH-1]);
        end
        ce_i = 1'b0; #1;
        checks++;
        if (inst_o !== 32'h0) begin
            errors++;
            $display("FAIL gate_ce_low: got %h expected 00000000", inst_o);
        end
    endtask

    task automatic test_restart();
        bq_t b;
        int ew;
        bit ee;
        b = '{8'h77, 8'h66};
        start_pulse();
        send(b, 1'b0, 0);
        ld_start_i = 1'b1;
        ld_valid_i = 1'b1;
        ld_byte_i  = 8'h99;
        tick();
        ld_start_i = 1'b0;
        ld_valid_i = 1'b0;
        checks++;
        if (ld_words_o !== '0 || ld_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: got words=%0d rdy=%b expected 0 1", ld_words_o, ld_ready_o);
        end
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        send(b, 1'b1, 0);
        model_load(b, 1'b1, ew, ee);
        ce_i = 1'b1;
        addr_i = 32'd0; #1;
        checks++;
        if (inst_o !== 32'h11223344 || ld_words_o !== 3'd1) begin
            errors++;
            $display("FAIL restart_word0: got %h words=%0d expected 11223344 1", inst_o, ld_words_o);
        end
        ce_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_midload();
        bq_t b;
        int ew;
        bit ee;
        b = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        start_pulse();
        send(b, 1'b0, 0);
        model_load(b, 1'b0, ew, ee);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || ld_ready_o !== 1'b0 || ld_words_o !== '0 || ld_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_midload: got busy=%b rdy=%b words=%0d err=%b expected 0 0 0 0",
                     busy_o, ld_ready_o, ld_words_o, ld_err_o);
        end
        tick();
        rst = 1'b1;
        tick();
        ce_i = 1'b1;
        addr_i = 32'd2; #1;
        checks++;
        if (inst_o !== 32'hC1C2C3C4 || inst_o !== mm[0]) begin
            errors++;
            $display("FAIL retained_word0: got %h expected c1c2c3c4", inst_o);
        end
        ce_i = 1'b0;
    endtask

    task automatic test_random();
        bq_t b;
        int ew;
        bit ee;
        int n;
        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(4 * DEPTH, 1);
            b = {};
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            start_pulse();
            send(b, 1'b1, 2);
            model_load(b, 1'b1, ew, ee);
            checks++;
            if (ld_done_o !== 1'b1 || ld_words_o !== (AW+1)'(ew) || ld_err_o !== 1'b0) begin
                errors++;
                $display("FAIL rand_load%0d: got done=%b words=%0d err=%b expected 1 %0d 0",
                         r, ld_done_o, ld_words_o, ld_err_o, ew);
            end
            tick();
            ce_i = 1'b1;
            for (int w = 0; w < DEPTH; w++) begin
                if (mvalid[w]) begin
                    addr_i = {28'h0, 2'(w), 2'($urandom)};
                    #1;
                    checks++;
                    if (inst_o !== mm[w]) begin
                        errors++;
                        $display("FAIL rand_fetch%0d_w%0d: got %h expected %h", r, w, inst_o, mm[w]);
                    end
                end
            end
            ce_i = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        ce_i = 1'b0;
        addr_i = 32'h0;
        ld_start_i = 1'b0;
        ld_valid_i = 1'b0;
        ld_byte_i = 8'h0;
        ld_last_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mm[i] = 32'h0;
            mvalid[i] = 1'b0;
        end
        tick();
        rst = 1'b1;
        tick();
        test_reset();
        test_full_word();
        test_partial();
        test_overflow();
        test_boundary_full();
        test_gating();
        test_restart();
        test_reset_midload();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Instruction-memory responder for the core's fetch port: answers `ce`/`addr` requests from the program counter with a 32-bit instruction word in the same cycle. It also has a byte-serial load port with a valid/ready handshake, so a host can fill the memory after reset. It sits beside the core at top level, driving the core's `rom_data_i` from the core's `rom_addr_o` and `rom_ce_o`.

## Interface
- `ADDR_W`, 10, word-address width; memory depth = 2^ADDR_W words of 32 bits.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `ce_i`  in  1  fetch enable from the core.
- `addr_i`  in  32  fetch byte address.
- `inst_o`  out  32  instruction word returned to the core.
- `busy_o`  out  1  high while a load is in progress or the loader is in error.
- `ld_start_i`  in  1  one-cycle pulse that begins a load at word 0.
- `ld_valid_i`  in  1  a load byte is present.
- `ld_byte_i`  in  8  load byte.
- `ld_last_i`  in  1  qualifies the current byte as the final byte of the image.
- `ld_ready_o`  out  1  the loader accepts a byte this cycle.
- `ld_done_o`  out  1  one-cycle pulse when a load completes.
- `ld_err_o`  out  1  overflow flag; held until the next `ld_start_i` or reset.
- `ld_words_o`  out  ADDR_W+1  number of words written by the current or last load.

## Operation
- **States:** IDLE, LOAD, ERR. Reset puts the block in IDLE.
- **Reset values:**
  - `ld_ready_o` = 0, `ld_done_o` = 0, `ld_err_o` = 0, `busy_o` = 0.
  - `ld_words_o` = 0; byte counter = 0; assembly register = 0.
  - Memory contents are not reset. Benches must not depend on unwritten locations.
- **Fetch read path** (combinational, asynchronous read):
  - `inst_o` = mem[`addr_i[ADDR_W+1:2]`] when all of the following hold: `ce_i`=1, state is IDLE, and `addr_i[31:ADDR_W+2]`=0.
  - Otherwise `inst_o` = 32'h0 (NOP).
  - `addr_i[1:0]` are ignored.
- **`busy_o`** = (state != IDLE).
- **IDLE:**
  - `ld_ready_o` = 0; bytes are ignored.
  - `ld_start_i` moves to LOAD and clears the byte counter, the word pointer (`ld_words_o`) and `ld_err_o`.
- **LOAD:**
  - `ld_ready_o` = 1. A byte transfers when `ld_valid_i` && `ld_ready_o`.
  - Bytes are packed big-endian: the first byte lands in [31:24], the fourth in [7:0].
  - On the 4th byte, the word is written to mem[`ld_words_o`], `ld_words_o` increments, and the byte counter returns to 0.
  - On a byte with `ld_last_i`=1:
    - The word is written immediately; unfilled low bytes are 0. A word with zero bytes received is not written.
    - `ld_done_o` pulses for the next cycle and the state returns to IDLE.
  - Overflow: a transfer that would start word index 2^ADDR_W (memory already full) is dropped, and the state moves to ERR.
  - A word completing exactly at index 2^ADDR_W-1 with `ld_last_i` is legal and is not an error.
- **ERR:**
  - `ld_ready_o` = 0, `ld_err_o` = 1, `busy_o` = 1.
  - Leaves only on `ld_start_i` (to LOAD) or reset.
- **Simultaneous events:**
  - `ld_start_i` together with a valid byte while in LOAD: the restart wins, the byte is dropped, and counters clear.
  - `ld_start_i` in IDLE together with `ld_valid_i`: the byte is ignored, since `ld_ready_o` was 0.
- **Reset mid-load:** the state goes to IDLE immediately and asynchronously, counters clear, and words already written are retained.
- **Width rule:** `ld_words_o` saturates at 2^ADDR_W; it never wraps.

## Timing
- Fetch latency: 0 cycles. `inst_o` follows `addr_i`/`ce_i` combinationally, matching the single-cycle core, which decodes the fetched word in the same cycle as the PC.
- A memory write commits on the rising edge that accepts the 4th byte or the last byte. The word is readable by fetch in the first IDLE cycle after that edge.
- `ld_ready_o` is a registered function of state: 1 from the first cycle after `ld_start_i` through the cycle that accepts the last byte.
- `ld_done_o` is high for exactly one cycle: the first IDLE cycle after the last byte.
- Maximum throughput: one byte per cycle.
- Asynchronous reset assertion forces every output listed under reset values immediately, with no clock required. Release is synchronous to `clk`; the external reset synchronizer is responsible for that.

## Test plan
- **Reset:** assert `rst`=0 mid-run → all load outputs are 0, `busy_o`=0; `inst_o`=0 while `ce_i`=0.
- **Full-word load:** `ld_start_i`, then bytes 34,01,00,20 and 34,02,00,30 (last on the 8th byte), one per cycle → `ld_done_o` pulses once and `ld_words_o`=2. Then fetch with `ce_i`=1: addr 0 → 32'h34010020, addr 4 → 32'h34020030, addr 5 → 32'h34020030.
- **Partial last word:** load 6 bytes AA,BB,CC,DD,EE,FF with last on FF → mem[1]=32'hEEFF0000 and `ld_words_o`=2.
- **Overflow:** with ADDR_W=2, send 17 bytes with no last → the 17th byte is dropped, state is ERR, `ld_err_o`=1, `busy_o`=1, `ld_words_o`=4. A subsequent `ld_start_i` clears `ld_err_o`.
- **Fetch gating:**
  - During LOAD, `ce_i`=1 at addr 0 → `inst_o`=0.
  - In IDLE, addr 32'h1000_0000 → `inst_o`=0 (out of range).
  - `ce_i`=0 → `inst_o`=0.
- **Restart and reset mid-load:**
  - After 2 bytes, `ld_start_i` with `ld_valid_i`=1 → that byte is dropped. Reloading 4 bytes then writes word 0 with the new bytes only.
  - `rst` asserted after 5 bytes → IDLE, `ld_words_o`=0, and word 0 from before the reset is still fetchable.
